dmem_host_port: RTL and testbench

//  Sits directly upstream of the 16x8 data memory and owns its ports. It passes the CPU's

---
 rtl/dmem_host_port_pkg.sv | 22 ++
 rtl/dmem_host_port_if.sv | 28 ++
 rtl/dmem_host_port.sv | 116 +++++++++++
 tb/tb_dmem_host_port.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_host_port_pkg.sv
// Shared widths, burst opcodes and FSM encoding for the data-memory host port.
package dmem_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_DUMP = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_DUMP_RD   = 3'd2,
    ST_DUMP_WAIT = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // A zero length field means a full-memory burst.
  function automatic logic [ADDR_W:0] burst_len(input logic [ADDR_W-1:0] len);
    return (len == '0) ? (ADDR_W+1)'(DEPTH) : {1'b0, len};
  endfunction
endpackage

// File: rtl/dmem_host_port_if.sv
// Host-side command, LOAD-stream and DUMP-stream handshakes plus burst status.
interface dmem_host_port_if;
  import dmem_pkg::*;

  logic              CmdValid;
  logic              CmdReady;
  logic              CmdOp;
  logic [ADDR_W-1:0] CmdAddr;
  logic [ADDR_W-1:0] CmdLen;
  logic              InValid;
  logic              InReady;
  logic [DATA_W-1:0] InData;
  logic              OutValid;
  logic              OutReady;
  logic [DATA_W-1:0] OutData;
  logic              Done;
  logic              Busy;

  modport master (
    output CmdValid, CmdOp, CmdAddr, CmdLen, InValid, InData, OutReady,
    input  CmdReady, InReady, OutValid, OutData, Done, Busy
  );

  modport slave (
    input  CmdValid, CmdOp, CmdAddr, CmdLen, InValid, InData, OutReady,
    output CmdReady, InReady, OutValid, OutData, Done, Busy
  );
endinterface

// File: rtl/dmem_host_port.sv
// Owns the 16x8 memory ports: CPU pass-through when idle, host LOAD/DUMP bursts otherwise.
// LOAD: 1 byte/cycle; DUMP: registered output, 1 byte per 2 cycles, held until OutReady.
module dmem_host_port
  import dmem_pkg::*;
(
  input  logic              Clock,
  input  logic              Resetn,
  dmem_host_port_if.slave   host,
  output logic              CpuWriteDropped,
  input  logic [ADDR_W-1:0] CpuReadSel,
  output logic [DATA_W-1:0] CpuDataOut,
  input  logic              CpuWriteEn,
  input  logic [ADDR_W-1:0] CpuWriteSel,
  input  logic [DATA_W-1:0] CpuDataIn,
  output logic [ADDR_W-1:0] MemReadSelect,
  input  logic [DATA_W-1:0] MemDataOut,
  output logic              MemWriteEn,
  output logic [ADDR_W-1:0] MemWriteSelect,
  output logic [DATA_W-1:0] MemDataIn
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic              out_vld;
  logic [DATA_W-1:0] out_dat;
  logic              done;
  logic              wr_dropped;
  logic              last_beat;

  assign last_beat = (cnt == (ADDR_W+1)'(1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      out_vld    <= 1'b0;
      out_dat    <= '0;
      done       <= 1'b0;
      wr_dropped <= 1'b0;
    end else begin
      done <= 1'b0;
      if (CpuWriteEn && state != ST_IDLE)
        wr_dropped <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (host.CmdValid) begin
            ptr        <= host.CmdAddr;
            cnt        <= burst_len(host.CmdLen);
            wr_dropped <= 1'b0;
            state      <= (host.CmdOp == OP_LOAD) ? ST_LOAD : ST_DUMP_RD;
          end
        end
        ST_LOAD: begin
          if (host.InValid) begin
            ptr <= ptr + 1'b1;
            cnt <= cnt - 1'b1;
            if (last_beat) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DUMP_RD: begin
          out_dat <= MemDataOut;
          out_vld <= 1'b1;
          state   <= ST_DUMP_WAIT;
        end
        ST_DUMP_WAIT: begin
          if (host.OutReady) begin
            out_vld <= 1'b0;
            ptr     <= ptr + 1'b1;
            cnt     <= cnt - 1'b1;
            if (last_beat) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_DUMP_RD;
            end
          end
        end
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Memory port steering; the CPU only reaches the write port while idle.
  always_comb begin
    MemReadSelect  = CpuReadSel;
    MemWriteEn     = 1'b0;
    MemWriteSelect = CpuWriteSel;
    MemDataIn      = CpuDataIn;
    case (state)
      ST_IDLE: MemWriteEn = CpuWriteEn;
      ST_LOAD: begin
        MemWriteEn     = host.InValid;
        MemWriteSelect = ptr;
        MemDataIn      = host.InData;
      end
      ST_DUMP_RD, ST_DUMP_WAIT: MemReadSelect = ptr;
      default: ;
    endcase
  end

  assign host.CmdReady = (state == ST_IDLE);
  assign host.InReady  = (state == ST_LOAD);
  assign host.Busy     = (state != ST_IDLE);
  assign host.OutValid = out_vld;
  assign host.OutData  = out_dat;
  assign host.Done     = done;
  assign CpuWriteDropped = wr_dropped;
  assign CpuDataOut      = MemDataOut;

endmodule

// File: tb/tb_dmem_host_port.sv
// Bench for dmem_host_port with a behavioural 16x8 memory and a DUMP scoreboard.
module tb_dmem_host_port;
  import dmem_pkg::*;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic              Resetn;
  logic              CpuWriteDropped;
  logic [ADDR_W-1:0] CpuReadSel, CpuWriteSel, MemReadSelect, MemWriteSelect;
  logic [DATA_W-1:0] CpuDataOut, CpuDataIn, MemDataOut, MemDataIn;
  logic              CpuWriteEn, MemWriteEn;

  dmem_host_port_if hif();

  dmem_host_port dut (
    .Clock          (Clock),
    .Resetn         (Resetn),
    .host           (hif),
    .CpuWriteDropped(CpuWriteDropped),
    .CpuReadSel     (CpuReadSel),
    .CpuDataOut     (CpuDataOut),
    .CpuWriteEn     (CpuWriteEn),
    .CpuWriteSel    (CpuWriteSel),
    .CpuDataIn      (CpuDataIn),
    .MemReadSelect  (MemReadSelect),
    .MemDataOut     (MemDataOut),
    .MemWriteEn     (MemWriteEn),
    .MemWriteSelect (MemWriteSelect),
    .MemDataIn      (MemDataIn)
  );

  logic [DATA_W-1:0] mem  [DEPTH] = '{default: 8'h00};
  logic [DATA_W-1:0] gold [DEPTH] = '{default: 8'h00};

  always @(posedge Clock) if (MemWriteEn) mem[MemWriteSelect] <= MemDataIn;
  assign MemDataOut = mem[MemReadSelect];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected DUMP bytes, popped on each accepted handshake.
  logic [DATA_W-1:0] exp_q[$];
  int                rx_cnt = 0;
  logic              held_vld = 1'b0;
  logic [DATA_W-1:0] held_dat = '0;

  always @(negedge Clock) begin
    if (hif.OutValid && held_vld) check_eq("out_hold", hif.OutData, held_dat);
    held_vld = hif.OutValid && !hif.OutReady;
    held_dat = hif.OutData;
    if (hif.OutValid && hif.OutReady) begin
      rx_cnt++;
      check_eq("dump_q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_eq("dump_byte", hif.OutData, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send_cmd(input logic op, input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] len);
    int t = 0;
    hif.CmdValid = 1'b1;
    hif.CmdOp    = op;
    hif.CmdAddr  = addr;
    hif.CmdLen   = len;
    while (!hif.CmdReady && t < 50) begin tick(); t++; end
    check_eq("cmd_ready", hif.CmdReady, 1);
    tick();
    hif.CmdValid = 1'b0;
  endtask

  task automatic load_beats(input logic [ADDR_W-1:0] start, input int n, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      logic [ADDR_W-1:0] a;
      a = start + ADDR_W'(i);
      hif.InValid = 1'b1;
      hif.InData  = base + DATA_W'(i);
      while (!hif.InReady && t < 50) begin tick(); t++; end
      check_eq("in_ready", hif.InReady, 1);
      gold[a] = hif.InData;
      tick();
    end
    hif.InValid = 1'b0;
  endtask

  task automatic check_mem(input logic [ADDR_W-1:0] a, input string tag);
    CpuReadSel = a;
    #1;
    check_eq(tag, CpuDataOut, gold[a]);
  endtask

  task automatic run_dump(input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] len);
    int n;
    logic done_seen;
    logic [ADDR_W-1:0] last_a;
    n = (len == 0) ? DEPTH : int'(len);
    for (int i = 0; i < n; i++) begin
      logic [ADDR_W-1:0] a;
      a = addr + ADDR_W'(i);
      exp_q.push_back(gold[a]);
    end
    last_a = addr + ADDR_W'(n - 1);
    rx_cnt = 0;
    done_seen = 1'b0;
    send_cmd(OP_DUMP, addr, len);
    for (int c = 0; c < 400 && !done_seen; c++) begin
      hif.OutReady = 1'($urandom_range(0, 1));
      tick();
      done_seen = hif.Done;
    end
    hif.OutReady = 1'b0;
    check_eq("dump_done", done_seen, 1);
    check_eq("dump_count", rx_cnt, n);
    check_eq("dump_q_empty", exp_q.size(), 0);
    check_eq("dump_outvalid_after", hif.OutValid, 0);
    check_eq("dump_outdata_kept", hif.OutData, gold[last_a]);
    tick();
  endtask

  initial begin
    Resetn       = 1'b0;
    hif.CmdValid = 1'b0;
    hif.CmdOp    = OP_LOAD;
    hif.CmdAddr  = '0;
    hif.CmdLen   = '0;
    hif.InValid  = 1'b0;
    hif.InData   = '0;
    hif.OutReady = 1'b0;
    CpuReadSel   = '0;
    CpuWriteEn   = 1'b0;
    CpuWriteSel  = '0;
    CpuDataIn    = '0;

    repeat (3) tick();
    check_eq("rst_cmdready", hif.CmdReady, 1);
    check_eq("rst_busy", hif.Busy, 0);
    check_eq("rst_outvalid", hif.OutValid, 0);
    check_eq("rst_outdata", hif.OutData, 0);
    check_eq("rst_done", hif.Done, 0);
    check_eq("rst_inready", hif.InReady, 0);
    check_eq("rst_dropped", CpuWriteDropped, 0);
    Resetn = 1'b1;
    tick();

    // Reset in the middle of an 8-beat LOAD.
    send_cmd(OP_LOAD, 4'd0, 4'd8);
    load_beats(4'd0, 3, 8'h10);
    check_eq("t1_busy_loading", hif.Busy, 1);
    Resetn = 1'b0;
    #2;
    check_eq("t1_busy", hif.Busy, 0);
    check_eq("t1_outvalid", hif.OutValid, 0);
    check_eq("t1_cmdready", hif.CmdReady, 1);
    tick();
    Resetn = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) check_mem(ADDR_W'(a), "t1_mem");

    // Wrapping LOAD with InValid held high.
    send_cmd(OP_LOAD, 4'd14, 4'd4);
    load_beats(4'd14, 4, 8'hA1);
    check_eq("t2_done_pulse", hif.Done, 1);
    tick();
    check_eq("t2_done_low", hif.Done, 0);
    check_eq("t2_idle", hif.CmdReady, 1);
    check_eq("t2_mem14", mem[14], 8'hA1);
    check_eq("t2_mem15", mem[15], 8'hA2);
    check_eq("t2_mem0", mem[0], 8'hA3);
    check_eq("t2_mem1", mem[1], 8'hA4);

    // CPU write during LOAD is discarded and flagged.
    send_cmd(OP_LOAD, 4'd8, 4'd2);
    CpuWriteEn  = 1'b1;
    CpuWriteSel = 4'd5;
    CpuDataIn   = 8'h55;
    tick();
    CpuWriteEn = 1'b0;
    load_beats(4'd8, 2, 8'hC0);
    tick();
    check_eq("t4_dropped", CpuWriteDropped, 1);
    check_mem(4'd5, "t4_mem5");
    check_mem(4'd9, "t4_mem9");

    // Full-memory DUMP with random backpressure; flag cleared by the accept.
    run_dump(4'd0, 4'd0);
    check_eq("t4_dropped_cleared", CpuWriteDropped, 0);

    // Command accepted in the same cycle as a CPU write.
    CpuWriteEn  = 1'b1;
    CpuWriteSel = 4'd3;
    CpuDataIn   = 8'h7E;
    gold[3]     = 8'h7E;
    send_cmd(OP_LOAD, 4'd4, 4'd1);
    CpuWriteEn = 1'b0;
    check_eq("t5_busy", hif.Busy, 1);
    check_eq("t5_not_dropped", CpuWriteDropped, 0);
    load_beats(4'd4, 1, 8'h5A);
    tick();
    check_mem(4'd3, "t5_mem3");
    check_mem(4'd4, "t5_mem4");

    // Short DUMP across the wrap point.
    run_dump(4'd15, 4'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
